// File: rtl/acc_flag_gen.sv
// Per-sample acceleration-region classifier: hysteresis/debounce FSM tagging each sample with acc, edge and zero flags.
// Optional statistics counter built only when ACC_FLAG_STAT_EN is defined.
module acc_flag_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             acc_en_i,
    input  logic             laser_vld_i,
    input  logic [15:0]      laser_data_i,
    input  logic [15:0]      acc_enter_thr_i,
    input  logic [15:0]      acc_exit_thr_i,
    input  logic [15:0]      zero_thr_i,
    input  logic [CNT_W-1:0] acc_min_len_i,
    input  logic [CNT_W-1:0] edge_guard_len_i,
    output logic             laser_vld_o,
    output logic [15:0]      laser_data_o,
    output logic             filter_acc_flag_o,
    output logic             recover_edge_flag_o,
    output logic             laser_zero_flag_o,
    output logic [15:0]      acc_region_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EDGE_IN  = 2'd1,
        ACC      = 2'd2,
        EDGE_OUT = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;

    logic             vld_q;
    logic [15:0]      data_q;
    logic             acc_flag_q, acc_flag_d;
    logic             edge_flag_q, edge_flag_d;
    logic             zero_flag_q;

    logic             is_low;
    logic             is_high;
    logic             is_zero;
    logic             guard_zero;
    logic [CNT_W-1:0] eff_min;
    logic [CNT_W-1:0] low_cnt_inc;
    logic [CNT_W-1:0] high_cnt_inc;
    logic [CNT_W-1:0] guard_cnt_dec;

    always_comb begin
        is_low        = (laser_data_i <  acc_enter_thr_i);
        is_high       = (laser_data_i >= acc_exit_thr_i);
        is_zero       = (laser_data_i <= zero_thr_i);
        guard_zero    = (edge_guard_len_i == '0);
        eff_min       = (acc_min_len_i == '0) ? CNT_W'(1) : acc_min_len_i;
        low_cnt_inc   = (low_cnt_q  == '1) ? low_cnt_q  : low_cnt_q  + CNT_W'(1);
        high_cnt_inc  = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + CNT_W'(1);
        guard_cnt_dec = (guard_cnt_q == '0) ? guard_cnt_q : guard_cnt_q - CNT_W'(1);
    end

    // Flags reflect the state the sample arrives in, before any transition it causes.
    always_comb begin
        acc_flag_d  = acc_en_i && (state_q != IDLE);
        edge_flag_d = acc_en_i && ((state_q == EDGE_IN) || (state_q == EDGE_OUT));
    end

    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        high_cnt_d  = high_cnt_q;
        guard_cnt_d = guard_cnt_q;

        if (!acc_en_i) begin
            state_d     = IDLE;
            low_cnt_d   = '0;
            high_cnt_d  = '0;
            guard_cnt_d = '0;
        end else if (laser_vld_i) begin
            case (state_q)
                IDLE: begin
                    if (!is_low) begin
                        low_cnt_d = '0;
                    end else if (low_cnt_inc >= eff_min) begin
                        low_cnt_d = '0;
                        if (guard_zero) begin
                            state_d    = ACC;
                            high_cnt_d = '0;
                        end else begin
                            state_d     = EDGE_IN;
                            guard_cnt_d = edge_guard_len_i;
                        end
                    end else begin
                        low_cnt_d = low_cnt_inc;
                    end
                end

                EDGE_IN: begin
                    // A high sample aborts the entry straight into the exit guard band.
                    if (is_high) begin
                        if (guard_zero) begin
                            state_d     = IDLE;
                            guard_cnt_d = '0;
                        end else begin
                            state_d     = EDGE_OUT;
                            guard_cnt_d = edge_guard_len_i;
                        end
                    end else if (guard_cnt_q <= CNT_W'(1)) begin
                        state_d     = ACC;
                        guard_cnt_d = '0;
                        high_cnt_d  = '0;
                    end else begin
                        guard_cnt_d = guard_cnt_dec;
                    end
                end

                ACC: begin
                    if (!is_high) begin
                        high_cnt_d = '0;
                    end else if (high_cnt_inc >= eff_min) begin
                        high_cnt_d = '0;
                        if (guard_zero) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = EDGE_OUT;
                            guard_cnt_d = edge_guard_len_i;
                        end
                    end else begin
                        high_cnt_d = high_cnt_inc;
                    end
                end

                EDGE_OUT: begin
                    if (guard_cnt_q <= CNT_W'(1)) begin
                        state_d     = IDLE;
                        guard_cnt_d = '0;
                    end else begin
                        guard_cnt_d = guard_cnt_dec;
                    end
                end

                default: begin
                    state_d     = IDLE;
                    low_cnt_d   = '0;
                    high_cnt_d  = '0;
                    guard_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            low_cnt_q   <= '0;
            high_cnt_q  <= '0;
            guard_cnt_q <= '0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            acc_flag_q  <= 1'b0;
            edge_flag_q <= 1'b0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            vld_q       <= laser_vld_i;
            if (laser_vld_i) begin
                data_q      <= laser_data_i;
                acc_flag_q  <= acc_flag_d;
                edge_flag_q <= edge_flag_d;
                zero_flag_q <= is_zero;
            end
        end
    end

`ifdef ACC_FLAG_STAT_EN
    logic [15:0] region_cnt_q;
    logic        enter_acc;

    always_comb begin
        enter_acc = acc_en_i && laser_vld_i && (state_q != ACC) && (state_d == ACC);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            region_cnt_q <= '0;
        end else if (!acc_en_i) begin
            region_cnt_q <= '0;
        end else if (enter_acc && (region_cnt_q != '1)) begin
            region_cnt_q <= region_cnt_q + 16'd1;
        end
    end

    assign acc_region_cnt_o = region_cnt_q;
`else
    assign acc_region_cnt_o = '0;
`endif

    assign laser_vld_o         = vld_q;
    assign laser_data_o        = data_q;
    assign filter_acc_flag_o   = acc_flag_q;
    assign recover_edge_flag_o = edge_flag_q;
    assign laser_zero_flag_o   = zero_flag_q;

endmodule
